// File: rtl/avmm_adder_seq_master.sv
// avmm_adder_seq_master: Avalon-MM master that writes operand A, operand B,
// waits a settle interval and reads back the adder result. Rev 1.0
`default_nettype none

module avmm_adder_seq_master #(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] BASE_A  = 32'h0000_0000,
  parameter logic [31:0] BASE_B  = 32'h0000_0010,
  parameter logic [31:0] BASE_R  = 32'h0000_0020,
  parameter int          OP_W    = 8,
  parameter int          RES_W   = 9,
  parameter int          SETTLE  = 2,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [OP_W-1:0]   op_a,
  input  logic [OP_W-1:0]   op_b,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [RES_W-1:0]  result,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int SET_W  = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_A   = 3'd1,
    S_WR_B   = 3'd2,
    S_SETTLE = 3'd3,
    S_RD_R   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, b_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic              accept, complete, timeout, in_xfer;
  logic [OP_W-1:0]   a_src;

  // Only the upper readdata bits beyond RES_W are intentionally ignored.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata;

  assign in_xfer = (state_q == S_WR_A) || (state_q == S_WR_B) || (state_q == S_RD_R);
  // Entering WR_A happens on the same edge that latches op_a, so use the live input.
  assign a_src   = accept ? op_a : a_q;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_WR_A;
        end
      end
      S_WR_A, S_WR_B, S_RD_R: begin
        if (!avm_waitrequest) begin
          complete = 1'b1;
          if (state_q == S_WR_A)
            state_d = S_WR_B;
          else if (state_q == S_RD_R)
            state_d = S_DONE;
          else if (SETTLE == 0)
            state_d = S_RD_R;
          else
            state_d = S_SETTLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SET_LAST)
          state_d = S_RD_R;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      wait_cnt      <= '0;
      settle_cnt    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      result        <= '0;
      avm_address   <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_writedata <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_d == S_DONE);

      // Command outputs are a registered decode of the next state, so they
      // hold steady across stalls and drop the cycle after completion.
      avm_write <= (state_d == S_WR_A) || (state_d == S_WR_B);
      avm_read  <= (state_d == S_RD_R);
      case (state_d)
        S_WR_A: begin
          avm_address   <= ADDR_W'(BASE_A);
          avm_writedata <= 32'(a_src);
        end
        S_WR_B: begin
          avm_address   <= ADDR_W'(BASE_B);
          avm_writedata <= 32'(b_q);
        end
        S_RD_R: begin
          avm_address   <= ADDR_W'(BASE_R);
          avm_writedata <= '0;
        end
        default: begin
          avm_address   <= '0;
          avm_writedata <= '0;
        end
      endcase

      if (accept) begin
        a_q    <= op_a;
        b_q    <= op_b;
        error  <= 1'b0;
        result <= '0;
      end
      if (timeout)
        error <= 1'b1;
      if (complete && (state_q == S_RD_R))
        result <= avm_readdata[RES_W-1:0];

      if (state_d != state_q)
        wait_cnt <= '0;
      else if (in_xfer && avm_waitrequest)
        wait_cnt <= wait_cnt + WAIT_W'(1);

      if ((state_q == S_SETTLE) && (state_d == S_SETTLE))
        settle_cnt <= settle_cnt + SET_W'(1);
      else
        settle_cnt <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_avmm_adder_seq_master.sv
// tb_avmm_adder_seq_master: scoreboard bench for the adder sequencing master.
`default_nettype none

module tb_avmm_adder_seq_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        sel;
  logic [7:0]  op_a, op_b;
  logic [31:0] rdata;
  logic        wreq;
  logic        start0, start1;

  logic        busy0, done0, error0, read0, write0;
  logic [8:0]  result0;
  logic [31:0] addr0, wdata0;
  logic        busy1, done1, error1, read1, write1;
  logic [8:0]  result1;
  logic [31:0] addr1, wdata1;

  logic        m_busy, m_done, m_error, m_read, m_write;
  logic [8:0]  m_result;
  logic [31:0] m_addr, m_wdata;

  int          lim_a, lim_b, lim_r;
  int          sa, sb, sr;
  logic [31:0] cyc;
  int          tests, fails;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [8:0]  res;
    logic        err;
    logic [31:0] at;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  avmm_adder_seq_master #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start0), .op_a(op_a), .op_b(op_b),
    .busy(busy0), .done(done0), .error(error0), .result(result0),
    .avm_address(addr0), .avm_read(read0), .avm_write(write0),
    .avm_writedata(wdata0), .avm_readdata(rdata), .avm_waitrequest(wreq)
  );

  avmm_adder_seq_master #(.SETTLE(0), .TIMEOUT(4)) dut_s0 (
    .clk(clk), .reset_n(reset_n), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .error(error1), .result(result1),
    .avm_address(addr1), .avm_read(read1), .avm_write(write1),
    .avm_writedata(wdata1), .avm_readdata(rdata), .avm_waitrequest(wreq)
  );

  always_comb begin
    if (sel) begin
      m_busy = busy1; m_done = done1; m_error = error1; m_read = read1;
      m_write = write1; m_result = result1; m_addr = addr1; m_wdata = wdata1;
    end else begin
      m_busy = busy0; m_done = done0; m_error = error0; m_read = read0;
      m_write = write0; m_result = result0; m_addr = addr0; m_wdata = wdata0;
    end
  end

  // Slave model: stalls the first lim_* cycles of each transfer to a register.
  assign wreq = (m_write && m_addr == 32'h00 && sa < lim_a) ||
                (m_write && m_addr == 32'h10 && sb < lim_b) ||
                (m_read  && sr < lim_r);

  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    sa  <= (m_write && m_addr == 32'h00) ? (wreq ? sa + 1 : sa) : 0;
    sb  <= (m_write && m_addr == 32'h10) ? (wreq ? sb + 1 : sb) : 0;
    sr  <= m_read ? (wreq ? sr + 1 : sr) : 0;
  end

  initial forever #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares completed bus transfers, stall stability and done results.
  initial begin
    bus_t        e;
    res_t        r;
    logic        hold_v;
    logic [63:0] hold_ad;
    logic [1:0]  hold_cmd;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_v = 1'b0;
      end else begin
        if (m_read && m_write) begin
          tests++; fails++;
          $display("FAIL rw_both: got read=1 write=1, expected at most one");
        end
        if (hold_v && (m_write || m_read)) begin
          check("stall_addr_data", {m_addr, m_wdata}, hold_ad);
          check("stall_cmd", {62'd0, m_write, m_read}, {62'd0, hold_cmd});
        end
        hold_v   = (m_write || m_read) && wreq;
        hold_ad  = {m_addr, m_wdata};
        hold_cmd = {m_write, m_read};
        if ((m_write || m_read) && !wreq) begin
          if (bus_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL bus_extra: got transfer w=%0b addr=0x%0h, expected none", m_write, m_addr);
          end else begin
            e = bus_q.pop_front();
            check("bus_cmd", {62'd0, m_write, m_read}, e.w ? 64'd2 : 64'd1);
            check("bus_addr", 64'(m_addr), 64'(e.addr));
            if (e.w) check("bus_wdata", 64'(m_wdata), 64'(e.data));
          end
        end
        if (m_done) begin
          if (res_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL done_extra: got done=1, expected no done");
          end else begin
            r = res_q.pop_front();
            check("done_result", 64'(m_result), 64'(r.res));
            check("done_error", 64'(m_error), 64'(r.err));
            check("done_cycle", 64'(cyc), 64'(r.at));
            check("done_busy", 64'(m_busy), 64'd1);
          end
        end
      end
    end
  end

  task automatic check_idle(input string name);
    check({name, "_ctrl"}, {59'd0, m_busy, m_done, m_error, m_read, m_write}, 64'd0);
    check({name, "_result"}, 64'(m_result), 64'd0);
    check({name, "_addr"}, 64'(m_addr), 64'd0);
    check({name, "_wdata"}, 64'(m_wdata), 64'd0);
  endtask

  task automatic push_bus(input logic [7:0] a, input logic [7:0] b, input bit with_read);
    bus_q.push_back('{w: 1'b1, addr: 32'h00, data: {24'd0, a}});
    bus_q.push_back('{w: 1'b1, addr: 32'h10, data: {24'd0, b}});
    if (with_read) bus_q.push_back('{w: 1'b0, addr: 32'h20, data: 32'd0});
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (res_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (res_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL done_wait: got no done within 200 cycles, expected done");
      res_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [31:0] rd,
                       input int la, input int lb, input int lr,
                       input logic [8:0] er, input logic ee, input int lat, input bit bus);
    @(negedge clk);
    op_a = a; op_b = b; rdata = rd;
    lim_a = la; lim_b = lb; lim_r = lr;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (bus) push_bus(a, b, 1'b1);
    res_q.push_back('{res: er, err: ee, at: cyc + 32'(lat)});
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    logic [31:0] c1;
    int          k;
    tests = 0; fails = 0;
    reset_n = 1'b0; start = 1'b0; sel = 1'b0;
    op_a = 8'h00; op_b = 8'h00; rdata = 32'd0;
    lim_a = 0; lim_b = 0; lim_r = 0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset0");
    sel = 1'b1; #1;
    check_idle("reset1");
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    do_op(8'h5A, 8'h33, 32'h0000_008D, 0, 0, 0, 9'h08D, 1'b0, 5, 1'b1);
    do_op(8'h5A, 8'h33, 32'h0000_008D, 0, 3, 2, 9'h08D, 1'b0, 10, 1'b1);
    do_op(8'h01, 8'h02, 32'hABCD_E123, 0, 0, 0, 9'h123, 1'b0, 5, 1'b1);
    do_op(8'h77, 8'h88, 32'h0000_0055, 1000, 0, 0, 9'h000, 1'b1, 4, 1'b0);
    check("timeout_write_dropped", 64'(m_write), 64'd0);

    // start held high through a whole operation and into the next IDLE cycle
    @(negedge clk);
    op_a = 8'h11; op_b = 8'h22; rdata = 32'h0000_0033;
    lim_a = 0; lim_b = 0; lim_r = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    push_bus(8'h11, 8'h22, 1'b1);
    res_q.push_back('{res: 9'h033, err: 1'b0, at: cyc + 32'd5});
    op_a = 8'h44; op_b = 8'h55;
    repeat (6) @(posedge clk);
    #1;
    check("idle_gap_busy", 64'(m_busy), 64'd0);
    rdata = 32'h0000_01AB;
    @(posedge clk);
    #1;
    c1 = cyc;
    push_bus(8'h44, 8'h55, 1'b1);
    res_q.push_back('{res: 9'h1AB, err: 1'b0, at: c1 + 32'd5});
    @(negedge clk);
    start = 1'b0;
    wait_done();
    wait_done();

    // reset while the read is stalled
    @(negedge clk);
    op_a = 8'h0F; op_b = 8'h01; rdata = 32'h0000_0010;
    lim_a = 0; lim_b = 0; lim_r = 1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    push_bus(8'h0F, 8'h01, 1'b0);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!m_read && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rd_reached", 64'(m_read), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    lim_r = 0;
    do_op(8'h0F, 8'h01, 32'h0000_0010, 0, 0, 0, 9'h010, 1'b0, 5, 1'b1);

    // SETTLE=0 build
    sel = 1'b1;
    do_op(8'hFF, 8'hFF, 32'h0000_01FE, 0, 0, 0, 9'h1FE, 1'b0, 3, 1'b1);

    check("bus_queue_empty", 64'(bus_q.size()), 64'd0);
    check("res_queue_empty", 64'(res_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
